pipeline_hazard_controller: RTL and testbench

Central stall/flush scheduler for the five-stage RISC-V pipeline. It watches the register addresses of the instruction in decode, the load/destination fields of the instruction in execute, the taken-branch signal, and the two cache ready lines. It drives the STALL/CLEAR inputs of the program-counter, fetch, decoding, execution and memory stages, so that load-use hazards, branch mispredictions and cache misses are resolved without corrupting pipeline registers. It replaces the per-stage ad-hoc tie-offs currently in the top level.

---
 rtl/pipeline_hazard_controller_if.sv | 53 +++++
 rtl/pipeline_hazard_controller.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Purpose: bundles the hazard inputs and the STALL/CLEAR outputs between the
//   five-stage pipeline and its central hazard controller.
// Latency: wires only. Backpressure: none; STALL lines are the pipeline's own hold.
// Ports: decode rs1/rs2, execute rd/write-enable/load code, branch taken, memory
//   access, cache ready lines (pipeline -> controller); five STALLs and two CLEARs
//   (controller -> pipeline). Statistics counters exist only with HAZARD_STATS_EN.
// modport master: the controller; modport slave: the pipeline.
interface pipeline_hazard_controller_if;
  logic [4:0]  DEC_RS1_ADDRESS;
  logic [4:0]  DEC_RS2_ADDRESS;
  logic [4:0]  EX_RD_ADDRESS;
  logic        EX_RD_WRITE_ENABLE;
  logic [2:0]  EX_DATA_CACHE_LOAD;
  logic        BRANCH_TAKEN;
  logic        MEM_ACCESS;
  logic        DATA_CACHE_READY;
  logic        INS_CACHE_READY;
  logic        STALL_PROGRAME_COUNTER_STAGE;
  logic        STALL_INSTRUCTION_FETCH_STAGE;
  logic        CLEAR_INSTRUCTION_FETCH_STAGE;
  logic        STALL_DECODING_STAGE;
  logic        CLEAR_DECODING_STAGE;
  logic        STALL_EXECUTION_STAGE;
  logic        STALL_MEMORY_STAGE;
`ifdef HAZARD_STATS_EN
  logic [31:0] STALL_CYCLE_COUNT;
  logic [31:0] FLUSH_COUNT;
`endif

  modport master (
    input  DEC_RS1_ADDRESS, DEC_RS2_ADDRESS, EX_RD_ADDRESS, EX_RD_WRITE_ENABLE,
           EX_DATA_CACHE_LOAD, BRANCH_TAKEN, MEM_ACCESS, DATA_CACHE_READY,
           INS_CACHE_READY,
`ifdef HAZARD_STATS_EN
    output STALL_CYCLE_COUNT, FLUSH_COUNT,
`endif
    output STALL_PROGRAME_COUNTER_STAGE, STALL_INSTRUCTION_FETCH_STAGE,
           CLEAR_INSTRUCTION_FETCH_STAGE, STALL_DECODING_STAGE,
           CLEAR_DECODING_STAGE, STALL_EXECUTION_STAGE, STALL_MEMORY_STAGE
  );

  modport slave (
    output DEC_RS1_ADDRESS, DEC_RS2_ADDRESS, EX_RD_ADDRESS, EX_RD_WRITE_ENABLE,
           EX_DATA_CACHE_LOAD, BRANCH_TAKEN, MEM_ACCESS, DATA_CACHE_READY,
           INS_CACHE_READY,
`ifdef HAZARD_STATS_EN
    input  STALL_CYCLE_COUNT, FLUSH_COUNT,
`endif
    input  STALL_PROGRAME_COUNTER_STAGE, STALL_INSTRUCTION_FETCH_STAGE,
           CLEAR_INSTRUCTION_FETCH_STAGE, STALL_DECODING_STAGE,
           CLEAR_DECODING_STAGE, STALL_EXECUTION_STAGE, STALL_MEMORY_STAGE
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Purpose: central stall/flush scheduler resolving load-use, branch and cache-miss hazards.
// Latency: outputs are combinational from state, bubble counter and current inputs (0 cycles).
// Backpressure: a data miss holds all five stages until DATA_CACHE_READY; i-miss holds PC.
// Ports: CLK, RST (async, active-high) plus the master side of pipeline_hazard_controller_if.
// Optional: define HAZARD_STATS_EN to add STALL_CYCLE_COUNT and FLUSH_COUNT (saturating).
module pipeline_hazard_controller #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter logic        HIGH             = 1'b1,
  parameter logic        LOW              = 1'b0
) (
  input  logic                                CLK,
  input  logic                                RST,
  pipeline_hazard_controller_if.master        hz
);

  typedef enum logic [1:0] {ST_RUN, ST_LOAD_BUBBLE, ST_DATA_WAIT} state_e;

  localparam logic [1:0] CNT_LOAD = 2'(LOAD_USE_BUBBLES - 1);

  state_e     state_q, state_d, ret_q, ret_d, eval_state;
  logic [1:0] cnt_q, cnt_d;

  logic lu, dm, im;
  logic stall_pc, stall_if, clear_if, stall_dec, clear_dec, stall_ex, stall_mem;
  logic flush;

  assign lu = (hz.EX_DATA_CACHE_LOAD != 3'b000) && hz.EX_RD_WRITE_ENABLE &&
              (hz.EX_RD_ADDRESS != 5'd0) &&
              ((hz.EX_RD_ADDRESS == hz.DEC_RS1_ADDRESS) ||
               (hz.EX_RD_ADDRESS == hz.DEC_RS2_ADDRESS));
  assign dm = hz.MEM_ACCESS && !hz.DATA_CACHE_READY;
  assign im = !hz.INS_CACHE_READY;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    cnt_d      = cnt_q;
    stall_pc   = 1'b0;
    stall_if   = 1'b0;
    clear_if   = 1'b0;
    stall_dec  = 1'b0;
    clear_dec  = 1'b0;
    stall_ex   = 1'b0;
    stall_mem  = 1'b0;
    flush      = 1'b0;
    eval_state = state_q;

    // In the ready cycle the wait dissolves and the return state runs as if
    // it had been current all along, so a resumed bubble sequence loses no cycle.
    if (state_q == ST_DATA_WAIT) begin
      if (hz.DATA_CACHE_READY) begin
        eval_state = ret_q;
      end else begin
        {stall_pc, stall_if, stall_dec, stall_ex, stall_mem} = 5'b11111;
      end
    end

    case (eval_state)
      ST_RUN: begin
        state_d = ST_RUN;
        if (dm) begin
          {stall_pc, stall_if, stall_dec, stall_ex, stall_mem} = 5'b11111;
          state_d = ST_DATA_WAIT;
          ret_d   = ST_RUN;
        end else if (hz.BRANCH_TAKEN) begin
          clear_if  = 1'b1;
          clear_dec = 1'b1;
          flush     = 1'b1;
        end else if (lu) begin
          stall_pc  = 1'b1;
          stall_if  = 1'b1;
          clear_dec = 1'b1;
          cnt_d     = CNT_LOAD;
          if (CNT_LOAD != 2'd0) state_d = ST_LOAD_BUBBLE;
        end else if (im) begin
          stall_pc = 1'b1;
          clear_if = 1'b1;
        end
      end
      ST_LOAD_BUBBLE: begin
        state_d = ST_LOAD_BUBBLE;
        if (dm) begin
          // Counter frozen so the remaining bubbles resume after the miss.
          {stall_pc, stall_if, stall_dec, stall_ex, stall_mem} = 5'b11111;
          state_d = ST_DATA_WAIT;
          ret_d   = ST_LOAD_BUBBLE;
        end else if (hz.BRANCH_TAKEN) begin
          clear_if  = 1'b1;
          clear_dec = 1'b1;
          flush     = 1'b1;
          cnt_d     = 2'd0;
          state_d   = ST_RUN;
        end else begin
          stall_pc  = 1'b1;
          stall_if  = 1'b1;
          clear_dec = 1'b1;
          if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = ST_RUN;
        end
      end
      default: ;  // data wait, cache not ready: full stall set above
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  // While in reset the pipeline is held flushed: CLEARs high, STALLs low.
  assign hz.STALL_PROGRAME_COUNTER_STAGE  = (!RST && stall_pc)  ? HIGH : LOW;
  assign hz.STALL_INSTRUCTION_FETCH_STAGE = (!RST && stall_if)  ? HIGH : LOW;
  assign hz.STALL_DECODING_STAGE          = (!RST && stall_dec) ? HIGH : LOW;
  assign hz.STALL_EXECUTION_STAGE         = (!RST && stall_ex)  ? HIGH : LOW;
  assign hz.STALL_MEMORY_STAGE            = (!RST && stall_mem) ? HIGH : LOW;
  assign hz.CLEAR_INSTRUCTION_FETCH_STAGE = (RST || clear_if)   ? HIGH : LOW;
  assign hz.CLEAR_DECODING_STAGE          = (RST || clear_dec)  ? HIGH : LOW;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_pc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (flush_cnt_q != 32'hFFFF_FFFF))    flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.STALL_CYCLE_COUNT = stall_cnt_q;
  assign hz.FLUSH_COUNT       = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  // Output vector order: {stall_pc, stall_if, clear_if, stall_dec, clear_dec, stall_ex, stall_mem}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] LU = 7'b1100100;
  localparam logic [6:0] DM = 7'b1101011;
  localparam logic [6:0] BR = 7'b0010100;
  localparam logic [6:0] IM = 7'b1010000;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic we, br, mem, dr, ir;
  logic [2:0] ld;

  int checks = 0;
  int failures = 0;
  int pc3;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if if2 ();
  pipeline_hazard_controller_if if3 ();

  assign if2.DEC_RS1_ADDRESS = rs1;  assign if3.DEC_RS1_ADDRESS = rs1;
  assign if2.DEC_RS2_ADDRESS = rs2;  assign if3.DEC_RS2_ADDRESS = rs2;
  assign if2.EX_RD_ADDRESS = rd;     assign if3.EX_RD_ADDRESS = rd;
  assign if2.EX_RD_WRITE_ENABLE = we; assign if3.EX_RD_WRITE_ENABLE = we;
  assign if2.EX_DATA_CACHE_LOAD = ld; assign if3.EX_DATA_CACHE_LOAD = ld;
  assign if2.BRANCH_TAKEN = br;      assign if3.BRANCH_TAKEN = br;
  assign if2.MEM_ACCESS = mem;       assign if3.MEM_ACCESS = mem;
  assign if2.DATA_CACHE_READY = dr;  assign if3.DATA_CACHE_READY = dr;
  assign if2.INS_CACHE_READY = ir;   assign if3.INS_CACHE_READY = ir;

  pipeline_hazard_controller #(.LOAD_USE_BUBBLES(2)) u2 (.CLK(clk), .RST(rst), .hz(if2.master));
  pipeline_hazard_controller #(.LOAD_USE_BUBBLES(3)) u3 (.CLK(clk), .RST(rst), .hz(if3.master));

  logic [6:0] out2, out3;
  assign out2 = {if2.STALL_PROGRAME_COUNTER_STAGE, if2.STALL_INSTRUCTION_FETCH_STAGE,
                 if2.CLEAR_INSTRUCTION_FETCH_STAGE, if2.STALL_DECODING_STAGE,
                 if2.CLEAR_DECODING_STAGE, if2.STALL_EXECUTION_STAGE, if2.STALL_MEMORY_STAGE};
  assign out3 = {if3.STALL_PROGRAME_COUNTER_STAGE, if3.STALL_INSTRUCTION_FETCH_STAGE,
                 if3.CLEAR_INSTRUCTION_FETCH_STAGE, if3.STALL_DECODING_STAGE,
                 if3.CLEAR_DECODING_STAGE, if3.STALL_EXECUTION_STAGE, if3.STALL_MEMORY_STAGE};

  typedef struct {
    string      name;
    logic [6:0] e2;
    logic [6:0] e3;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       we;
    logic [2:0] ld;
    logic       br, mem, dr, ir;
    logic [6:0] exp;
  } vec_t;
  vec_t vt[16];

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic w, input logic [2:0] l, input logic bt,
                       input logic m, input logic d, input logic i);
    rs1 = a; rs2 = b; rd = c; we = w; ld = l; br = bt; mem = m; dr = d; ir = i;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic lu_in();
    drive(5'd1, 5'd5, 5'd5, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic dm_in(input logic ready);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b1, ready, 1'b1);
  endtask

  task automatic expect_out(input string nm, input logic [6:0] e2, input logic [6:0] e3);
    exp_t e;
    e.name = nm; e.e2 = e2; e.e3 = e3;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty got=0 entries want>=1");
    end else begin
      e = sb.pop_front();
      checks += 2;
      if (out2 !== e.e2) begin
        failures++;
        $display("FAIL %s bubbles2 got=%b want=%b", e.name, out2, e.e2);
      end
      if (out3 !== e.e3) begin
        failures++;
        $display("FAIL %s bubbles3 got=%b want=%b", e.name, out3, e.e3);
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string nm, input logic [6:0] e2, input logic [6:0] e3);
    expect_out(nm, e2, e3);
    #1;
    pc3 += int'(out3[6]);
    check_out();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //            rs1   rs2   rd    we    ld      br    mem   dr    ir    exp
    vt[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, Z};
    vt[1]  = '{5'd1, 5'd5, 5'd5, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, LU};
    vt[2]  = '{5'd7, 5'd0, 5'd7, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, LU};
    vt[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, Z};
    vt[4]  = '{5'd1, 5'd5, 5'd5, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, Z};
    vt[5]  = '{5'd1, 5'd5, 5'd5, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, Z};
    vt[6]  = '{5'd1, 5'd5, 5'd6, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1, Z};
    vt[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, DM};
    vt[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, Z};
    vt[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, Z};
    vt[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, BR};
    vt[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, BR};
    vt[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, IM};
    vt[13] = '{5'd1, 5'd5, 5'd5, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, LU};
    vt[14] = '{5'd1, 5'd5, 5'd5, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, BR};
    vt[15] = '{5'd1, 5'd5, 5'd5, 1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0, DM};

    pc3 = 0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    expect_out("reset_outputs", BR, BR);
    #1 check_out();

    // Single-cycle decode of RUN: reset is released only inside each check
    // window, so no clock edge ever advances state during the table.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      drive(vt[k].rs1, vt[k].rs2, vt[k].rd, vt[k].we, vt[k].ld,
            vt[k].br, vt[k].mem, vt[k].dr, vt[k].ir);
      rst = 1'b0;
      expect_out($sformatf("vec%0d", k), vt[k].exp, vt[k].exp);
      #1 check_out();
      rst = 1'b1;
    end

    @(negedge clk);
    idle();
    rst = 1'b0;
    @(negedge clk);

    // Load-use: 2 vs 3 bubbles, then back to idle.
    lu_in();  step("lu_c0", LU, LU);
    idle();   step("lu_c1", LU, LU);
              step("lu_c2", Z, LU);
              step("lu_c3", Z, Z);

    // rd = x0 never stalls.
    drive(5'd0, 5'd5, 5'd0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1);
    step("rd0_c0", Z, Z);
    idle();   step("rd0_c1", Z, Z);

    // Data miss, 4 not-ready cycles, stalls drop in the ready cycle.
    dm_in(1'b0);
    for (int k = 0; k < 4; k++) step($sformatf("dmiss_c%0d", k), DM, DM);
    dm_in(1'b1); step("dmiss_ready", Z, Z);
    idle();      step("dmiss_after", Z, Z);

    // Data miss in the 2nd bubble cycle (3-bubble instance), 2-cycle miss.
    pc3 = 0;
    lu_in();     step("mb_c0", LU, LU);
    idle();      step("mb_c1", LU, LU);
    dm_in(1'b0); step("mb_c2", DM, DM);
                 step("mb_c3", DM, DM);
    dm_in(1'b1); step("mb_ready", Z, LU);
    idle();      step("mb_after", Z, Z);
    checks++;
    if (pc3 != 3 + 2) begin
      failures++;
      $display("FAIL mb_pc_stall_cycles got=%0d want=%0d", pc3, 5);
    end

    // Branch with i-miss: flush wins, PC loads target.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
    step("br_imiss", BR, BR);
    idle();   step("br_after", Z, Z);

    // Branch during a bubble sequence cancels the remaining bubbles.
    lu_in();  step("brlb_c0", LU, LU);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
    step("brlb_c1", BR, BR);
    idle();   step("brlb_c2", Z, Z);

`ifdef HAZARD_STATS_EN
    checks++;
    if (if2.FLUSH_COUNT !== 32'd2) begin
      failures++;
      $display("FAIL flush_count got=%0d want=%0d", if2.FLUSH_COUNT, 2);
    end
`endif

    // Reset in the middle of a data wait.
    dm_in(1'b0); step("rw_c0", DM, DM);
    expect_out("rw_waiting", DM, DM);
    #1 check_out();
    rst = 1'b1;
    expect_out("rw_in_reset", BR, BR);
    #1 check_out();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_STATS_EN
    #1;
    checks += 2;
    if (if3.STALL_CYCLE_COUNT !== 32'd0) begin
      failures++;
      $display("FAIL stall_count_after_reset got=%0d want=0", if3.STALL_CYCLE_COUNT);
    end
    if (if3.FLUSH_COUNT !== 32'd0) begin
      failures++;
      $display("FAIL flush_count_after_reset got=%0d want=0", if3.FLUSH_COUNT);
    end
    @(negedge clk);
`endif
    step("rw_release_c0", Z, Z);
    idle();   step("rw_release_c1", Z, Z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
